// File: rtl/larpix_pkg.sv
// Shared larpix definitions: arbiter FSM states, source indices and
// small index helpers used by the TX source arbiter and its selector.
package larpix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam logic [1:0] SRC_CONFIG = 2'd0;
    localparam logic [1:0] SRC_FWD    = 2'd1;
    localparam logic [1:0] SRC_FIFO   = 2'd2;

    // One-hot (3 bit) to source index; zero maps to SRC_CONFIG.
    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = SRC_CONFIG;
        if (oh[SRC_FIFO]) begin
            idx = SRC_FIFO;
        end else if (oh[SRC_FWD]) begin
            idx = SRC_FWD;
        end
        return idx;
    endfunction

    // (idx + 1) mod 3
    function automatic logic [1:0] next_idx3(input logic [1:0] idx);
        return (idx == SRC_FIFO) ? SRC_CONFIG : idx + 2'd1;
    endfunction

endpackage

// File: rtl/tx_source_arbiter_if.sv
// Source/UART handshake bundle for the TX source arbiter.
// master: arbiter side (drives gnt, tx_data, ld_tx_data).
// slave : sources + UARTs (drive req, src_data*, tx_busy_any).
interface tx_source_arbiter_if #(
    parameter int WIDTH = 64
);
    logic [2:0]       req;
    logic [WIDTH-2:0] src_data0;
    logic [WIDTH-2:0] src_data1;
    logic [WIDTH-2:0] src_data2;
    logic             tx_busy_any;
    logic [2:0]       gnt;
    logic [WIDTH-2:0] tx_data;
    logic             ld_tx_data;

    modport master (
        input  req,
        input  src_data0,
        input  src_data1,
        input  src_data2,
        input  tx_busy_any,
        output gnt,
        output tx_data,
        output ld_tx_data
    );

    modport slave (
        output req,
        output src_data0,
        output src_data1,
        output src_data2,
        output tx_busy_any,
        input  gnt,
        input  tx_data,
        input  ld_tx_data
    );

endinterface

// File: rtl/tx_source_arbiter_rr_select3.sv
// Combinational 3-way winner select: fixed priority or round robin,
// with a forced win for the FIFO source. Outputs one-hot winner.
module tx_source_arbiter_rr_select3
    import larpix_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] pointer,
    input  logic       mode,
    input  logic       force_grant,
    output logic [2:0] winner
);

    always_comb begin
        winner = 3'b000;
        if (force_grant && req[SRC_FIFO]) begin
            winner = 3'b100;
        end else if (!mode) begin
            if (req[SRC_CONFIG]) begin
                winner = 3'b001;
            end else if (req[SRC_FWD]) begin
                winner = 3'b010;
            end else if (req[SRC_FIFO]) begin
                winner = 3'b100;
            end
        end else begin
            // Search starts at pointer and wraps modulo 3.
            case (pointer)
                SRC_FWD: begin
                    if (req[1]) winner = 3'b010;
                    else if (req[2]) winner = 3'b100;
                    else if (req[0]) winner = 3'b001;
                end
                SRC_FIFO: begin
                    if (req[2]) winner = 3'b100;
                    else if (req[0]) winner = 3'b001;
                    else if (req[1]) winner = 3'b010;
                end
                default: begin
                    if (req[0]) winner = 3'b001;
                    else if (req[1]) winner = 3'b010;
                    else if (req[2]) winner = 3'b100;
                end
            endcase
        end
    end

endmodule

// File: rtl/tx_source_arbiter.sv
// Arbitrates three packet sources onto the shared UART TX path.
// Ports: clk, reset_n_clk (async, active low); bus (master modport:
// req/src_data*/tx_busy_any in, gnt/tx_data/ld_tx_data out);
// enable_round_robin, clear_err in; arb_busy, last_winner, timeout_err out.
module tx_source_arbiter
    import larpix_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                reset_n_clk,
    tx_source_arbiter_if.master bus,
    input  logic                enable_round_robin,
    input  logic                clear_err,
    output logic                arb_busy,
    output logic [1:0]          last_winner,
    output logic                timeout_err
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    arb_state_t       state;
    logic [2:0]       gnt_q;
    logic [WIDTH-2:0] data_q;
    logic             ld_q;
    logic [1:0]       ptr;
    logic [2:0]       starve;
    logic [TW-1:0]    tmo;

    logic [2:0]       winner;
    logic [1:0]       win_idx;
    logic [WIDTH-2:0] win_data;
    logic             force_grant;

    assign force_grant = (int'(starve) >= STARVE_LIMIT);

    tx_source_arbiter_rr_select3 u_sel (
        .req         (bus.req),
        .pointer     (ptr),
        .mode        (enable_round_robin),
        .force_grant (force_grant),
        .winner      (winner)
    );

    assign win_idx = onehot3_to_idx(winner);

    always_comb begin
        win_data = bus.src_data0;
        case (win_idx)
            SRC_FWD:  win_data = bus.src_data1;
            SRC_FIFO: win_data = bus.src_data2;
            default:  win_data = bus.src_data0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            state       <= IDLE;
            gnt_q       <= '0;
            data_q      <= '0;
            ld_q        <= 1'b0;
            arb_busy    <= 1'b0;
            last_winner <= SRC_CONFIG;
            timeout_err <= 1'b0;
            ptr         <= SRC_CONFIG;
            starve      <= '0;
            tmo         <= '0;
        end else begin
            gnt_q <= '0;
            ld_q  <= 1'b0;
            // A timeout below overrides a same-cycle clear.
            if (clear_err) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if ((|bus.req) && !bus.tx_busy_any) begin
                        gnt_q       <= winner;
                        data_q      <= win_data;
                        last_winner <= win_idx;
                        ptr         <= next_idx3(win_idx);
                        if (winner[SRC_FIFO]) begin
                            starve <= '0;
                        end else if (bus.req[SRC_FIFO] && starve != 3'd7) begin
                            starve <= starve + 3'd1;
                        end
                        arb_busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    ld_q  <= 1'b1;
                    tmo   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy_any) begin
                        state <= WAIT_DONE;
                    end else if (tmo == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        arb_busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy_any) begin
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.tx_data    = data_q;
    assign bus.ld_tx_data = ld_q;

endmodule

// File: tb/tb_tx_source_arbiter.sv
// Directed bench for tx_source_arbiter with a grant scoreboard and a
// simple UART busy model.
module tb_tx_source_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rr = 1'b0;
    logic       clr = 1'b0;
    logic       arb_busy;
    logic [1:0] last_winner;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;
    int grants = 0;

    int   busy_len = 0;
    int   busy_cnt = 0;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;

    typedef struct packed {
        logic [1:0]  idx;
        logic [62:0] data;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   pend = 0;

    tx_source_arbiter_if #(.WIDTH(64)) bus ();

    assign bus.tx_busy_any = model_busy | force_busy;

    tx_source_arbiter #(
        .WIDTH(64),
        .STARVE_LIMIT(4),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clk                (clk),
        .reset_n_clk        (rst_n),
        .bus                (bus),
        .enable_round_robin (rr),
        .clear_err          (clr),
        .arb_busy           (arb_busy),
        .last_winner        (last_winner),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART model: busy for busy_len cycles after each load strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt   = 0;
            model_busy = 1'b0;
        end else begin
            #1;
            if (bus.ld_tx_data && busy_len > 0) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            model_busy = (busy_cnt > 0);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("ld_after_gnt", {63'd0, bus.ld_tx_data}, 64'd1);
                chk("tx_data", {1'b0, bus.tx_data}, {1'b0, cur.data});
                chk("last_winner", {62'd0, last_winner}, {62'd0, cur.idx});
                pend = 0;
            end else begin
                chk("no_stray_ld", {63'd0, bus.ld_tx_data}, 64'd0);
            end
            if (bus.gnt !== 3'b000) begin
                if (q.size() == 0) begin
                    chk("unexpected_gnt", {61'd0, bus.gnt}, 64'd0);
                end else begin
                    cur = q.pop_front();
                    chk("gnt", {61'd0, bus.gnt}, {61'd0, 3'b001 << cur.idx});
                    pend = 1;
                    grants++;
                end
            end
        end
    end

    task automatic wait_ld(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ld_tx_data && n < 50);
        chk(tag, {63'd0, bus.ld_tx_data}, 64'd1);
    endtask

    task automatic wait_grants(input int target, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grants < target && n < 400);
        chk(tag, 64'(grants), 64'(target));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((arb_busy || bus.tx_busy_any) && n < 100);
        chk(tag, {63'd0, arb_busy}, 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, {61'd0, bus.gnt}, 64'd0);
        chk({tag, "_tx_data"}, {1'b0, bus.tx_data}, 64'd0);
        chk({tag, "_ld"}, {63'd0, bus.ld_tx_data}, 64'd0);
        chk({tag, "_arb_busy"}, {63'd0, arb_busy}, 64'd0);
        chk({tag, "_last_winner"}, {62'd0, last_winner}, 64'd0);
        chk({tag, "_timeout_err"}, {63'd0, timeout_err}, 64'd0);
    endtask

    initial begin
        int g0;
        bus.req       = 3'b000;
        bus.src_data0 = 63'h0AAA_0000;
        bus.src_data1 = 63'h0BBB_0000;
        bus.src_data2 = 63'h0CCC_0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_arb_busy", {63'd0, arb_busy}, 64'd0);

        // Single request from source 1
        busy_len = 3;
        bus.src_data1 = 63'h1234;
        q.push_back(exp_t'{2'd1, 63'h1234});
        bus.req = 3'b010;
        @(negedge clk);
        chk("single_gnt", {61'd0, bus.gnt}, 64'b010);
        bus.req = 3'b000;
        @(negedge clk);
        chk("single_ld", {63'd0, bus.ld_tx_data}, 64'd1);
        chk("single_data", {1'b0, bus.tx_data}, 64'h1234);
        wait_idle("single_idle");

        // Fixed priority with starvation forcing source 2
        busy_len = 10;
        rr = 1'b0;
        bus.src_data0 = 63'h0A0A;
        bus.src_data2 = 63'h0C0C;
        for (int i = 0; i < 4; i++) q.push_back(exp_t'{2'd0, 63'h0A0A});
        q.push_back(exp_t'{2'd2, 63'h0C0C});
        g0 = grants;
        bus.req = 3'b111;
        wait_grants(g0 + 5, "fixed_grants");
        bus.req = 3'b000;
        wait_idle("fixed_idle");

        // Round robin
        busy_len = 2;
        rr = 1'b1;
        bus.src_data1 = 63'h0B0B;
        for (int i = 0; i < 2; i++) begin
            q.push_back(exp_t'{2'd0, 63'h0A0A});
            q.push_back(exp_t'{2'd1, 63'h0B0B});
            q.push_back(exp_t'{2'd2, 63'h0C0C});
        end
        g0 = grants;
        bus.req = 3'b111;
        wait_grants(g0 + 6, "rr_grants");
        bus.req = 3'b000;
        wait_idle("rr_idle");
        rr = 1'b0;

        // Busy timeout
        busy_len = 0;
        q.push_back(exp_t'{2'd0, 63'h0A0A});
        bus.req = 3'b001;
        wait_ld("tmo_ld");
        bus.req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tmo_err_early", {63'd0, timeout_err}, 64'd0);
            chk("tmo_busy_early", {63'd0, arb_busy}, 64'd1);
        end
        @(negedge clk);
        chk("tmo_err_set", {63'd0, timeout_err}, 64'd1);
        chk("tmo_back_idle", {63'd0, arb_busy}, 64'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("tmo_cleared", {63'd0, timeout_err}, 64'd0);

        // Timeout wins over a simultaneous clear
        clr = 1'b1;
        q.push_back(exp_t'{2'd0, 63'h0A0A});
        bus.req = 3'b001;
        wait_ld("tmo2_ld");
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("tmo_vs_clear", {63'd0, timeout_err}, 64'd1);
        @(negedge clk);
        chk("tmo2_cleared", {63'd0, timeout_err}, 64'd0);
        clr = 1'b0;

        // No grant while UART busy in IDLE
        busy_len = 2;
        force_busy = 1'b1;
        bus.req = 3'b100;
        repeat (5) begin
            @(negedge clk);
            chk("busy_hold_gnt", {61'd0, bus.gnt}, 64'd0);
            chk("busy_hold_arb", {63'd0, arb_busy}, 64'd0);
        end
        q.push_back(exp_t'{2'd2, 63'h0C0C});
        force_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_gnt", {61'd0, bus.gnt}, 64'b100);
        bus.req = 3'b000;
        wait_idle("busy_idle");

        // Reset in WAIT_DONE aborts the transfer
        busy_len = 20;
        q.push_back(exp_t'{2'd1, 63'h0B0B});
        bus.req = 3'b010;
        wait_ld("rst_ld");
        bus.req = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_in_wait_done", {63'd0, arb_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        busy_len = 2;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", {63'd0, arb_busy}, 64'd0);

        // First grant on the first edge after release
        rst_n = 1'b0;
        bus.src_data0 = 63'h55;
        bus.req = 3'b001;
        q.push_back(exp_t'{2'd0, 63'h55});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_edge_gnt", {61'd0, bus.gnt}, 64'b001);
        bus.req = 3'b000;
        wait_idle("final_idle");
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
